sram_lsu: RTL and testbench
===========================

# sram_lsu

Load/store unit that acts as the initiator on the dual-port `sram_4k` data memory: accepts one core memory request at a time (byte/half/word, signed/unsigned loads), drives SRAM write port A and read port B, and returns one response per request. Sub-word stores become read-modify-write sequences, because `sram_4k` has no byte enables. Sits between the FRiscV execute/memory stage and the data `sram_4k` instance.

## Interface
- `RAM_WIDTH`, default `ARCH` (32): SRAM word width; only 32 is supported.
- `RAM_DEPTH`, default 4096: SRAM size in bytes. `AW = $clog2(RAM_DEPTH)`.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_in` in 1: request strobe, sampled only while `ready_out`=1.
- `we_in` in 1: 1 = store, 0 = load.
- `addr_in` in 32: byte address.
- `size_in` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal.
- `unsigned_in` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `wdata_in` in 32: store data, right-aligned.
- `ready_out` out 1: idle and able to accept a request.
- `valid_out` out 1: one-cycle response pulse.
- `err_out` out 1: qualifies `valid_out`; the request was rejected.
- `rdata_out` out 32: load result, valid with `valid_out`; 0 for stores and errors.
- `addr_a_byte_out` out AW: SRAM port A byte address.
- `din_a_out` out 32: SRAM port A write data.
- `we_a_out` out 1: SRAM port A write enable.
- `en_b_out` out 1: SRAM port B read enable.
- `addr_b_byte_out` out AW: SRAM port B byte address.
- `dout_b_in` in 32: SRAM port B read data, valid the cycle after `en_b_out`.

## Operation
- SRAM model: word select = `addr[AW-1:2]`; `addr[1:0]` ignored. Synchronous read with 1-cycle latency. The LSU never reads and writes the same word in the same cycle.
- Byte lanes are little-endian. Offset `o = addr_in[1:0]`; the byte lives at `[8o+7:8o]` and the half at `[16(o/2)+15:16(o/2)]`.
- Request capture in IDLE when `req_in` is high: latch `we`, `size`, `unsigned`, `addr[AW-1:0]`, `wdata`.
- Error conditions:
  - `size_in`=11;
  - half with `o[0]`=1;
  - word with `o`≠0;
  - `addr_in >= RAM_DEPTH`.
  - On error: go to DONE with `err_out`=1. There is no SRAM access.
- FSM states: IDLE, RD, RD_WAIT, WR, DONE.
  - IDLE: `ready_out`=1. Valid load → RD. Word store → WR. Sub-word store → RD. Error → DONE.
  - RD: `en_b_out`=1, `addr_b_byte_out` = latched address. → RD_WAIT.
  - RD_WAIT: capture `dout_b_in`. Load → DONE with extracted and extended data. Store → WR with merged word (new lane(s) from `wdata[7:0]`/`[15:0]`, other lanes unchanged).
  - WR: `we_a_out`=1, `addr_a_byte_out` = latched address, `din_a_out` = `wdata` (word) or merged word. → DONE.
  - DONE: `valid_out`=1 for exactly one cycle; `err_out` and `rdata_out` as decided. → IDLE.
- All SRAM-side outputs and `valid_out`/`err_out`/`rdata_out` are registered.
- `en_b_out` and `we_a_out` are 0 outside RD and WR respectively.
- `req_in` while `ready_out`=0 is ignored (no queueing). The core holds the request until accepted.
- Sign extension: bit 7 (byte) or bit 15 (half) is replicated to bit 31 when `unsigned_in`=0. Word loads pass through unchanged.

## Timing
- Reset (async assert): state IDLE; `ready_out`=1; all other outputs 0.
  - Reset in WR forces `we_a_out`=0 immediately, so no partial write occurs.
  - An in-flight request is discarded with no response.
- Cycle 0 is the edge that accepts the request. `valid_out` is high during the cycle that begins at edge N:
  - errors: N=1;
  - word store: N=2;
  - load: N=3;
  - sub-word store: N=4.
- `ready_out` returns high in the cycle after DONE. Back-to-back throughput is therefore latency+1 cycles per request.
- `valid_out` never asserts without a prior accepted request. Exactly one `valid_out` per accepted request.

## Test plan
- Word store 0xDEADBEEF to 0x010, then word load from 0x010:
  - `we_a_out` pulses once with `din_a_out`=0xDEADBEEF;
  - load returns 0xDEADBEEF with `err_out`=0 and `valid_out` 3 cycles after acceptance.
- After the above, byte store 0xA5 to 0x012, then word load from 0x010 → 0xDEA5BEEF. Verify the read of 0x010 precedes the write and the store `valid_out` comes 4 cycles after acceptance.
- Half loads from 0x012, with the word at 0x010 = 0x8001_7FFF:
  - signed → 0xFFFF8001;
  - unsigned → 0x00008001;
  - signed byte load from 0x011 → 0x0000007F.
- Error requests, each giving `valid_out`=1, `err_out`=1 one cycle after acceptance, `en_b_out` and `we_a_out` never asserted:
  - half load at 0x013;
  - word store at 0x002;
  - `size_in`=11;
  - load at 0x1000 (`RAM_DEPTH`=4096).
- Reset is asserted during RD_WAIT of a byte store:
  - `we_a_out` stays 0 and no `valid_out` is produced;
  - `ready_out`=1 after reset;
  - a word load of the same address returns the pre-store value.
- A `req_in` pulse while busy is ignored: exactly one `valid_out` per accepted request, and SRAM contents match only the accepted requests.

Source files
------------

// File: rtl/sram_lsu.sv
// Load/store unit driving the dual-port sram_4k: one request at a time, sub-word
// stores done as read-modify-write because the SRAM has no byte enables.
module sram_lsu #(
    parameter  int RAM_WIDTH = 32,
    parameter  int RAM_DEPTH = 4096,
    localparam int AW        = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_in,
    input  logic                 we_in,
    input  logic [31:0]          addr_in,
    input  logic [1:0]           size_in,
    input  logic                 unsigned_in,
    input  logic [RAM_WIDTH-1:0] wdata_in,
    output logic                 ready_out,
    output logic                 valid_out,
    output logic                 err_out,
    output logic [RAM_WIDTH-1:0] rdata_out,
    output logic [AW-1:0]        addr_a_byte_out,
    output logic [RAM_WIDTH-1:0] din_a_out,
    output logic                 we_a_out,
    output logic                 en_b_out,
    output logic [AW-1:0]        addr_b_byte_out,
    input  logic [RAM_WIDTH-1:0] dout_b_in
);

    typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t               state;
    logic                 we_r;
    logic [1:0]           size_r;
    logic                 uns_r;
    logic [AW-1:0]        addr_r;
    logic [RAM_WIDTH-1:0] wdata_r;
    logic                 err_r;
    logic [RAM_WIDTH-1:0] res_r;
    logic                 req_err;

    function automatic logic [RAM_WIDTH-1:0] load_extract(
        input logic [RAM_WIDTH-1:0] word,
        input logic [1:0]           size,
        input logic [1:0]           off,
        input logic                 uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            SZ_BYTE: return uns ? {{(RAM_WIDTH-8){1'b0}}, b}  : {{(RAM_WIDTH-8){b[7]}}, b};
            SZ_HALF: return uns ? {{(RAM_WIDTH-16){1'b0}}, h} : {{(RAM_WIDTH-16){h[15]}}, h};
            default: return word;
        endcase
    endfunction

    // Replace only the addressed lane(s); the rest of the old word is kept.
    function automatic logic [RAM_WIDTH-1:0] store_merge(
        input logic [RAM_WIDTH-1:0] old_word,
        input logic [RAM_WIDTH-1:0] wdata,
        input logic [1:0]           size,
        input logic [1:0]           off
    );
        logic [RAM_WIDTH-1:0] w;
        w = old_word;
        case (size)
            SZ_BYTE: w[{off, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: w[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: w = wdata;
        endcase
        return w;
    endfunction

    always_comb begin
        req_err = 1'b0;
        if (size_in == 2'b11)                           req_err = 1'b1;
        if (size_in == SZ_HALF && addr_in[0])           req_err = 1'b1;
        if (size_in == SZ_WORD && addr_in[1:0] != 2'b0) req_err = 1'b1;
        if (addr_in >= 32'(RAM_DEPTH))                  req_err = 1'b1;
    end

    // NOTE: the asynchronous reset clears we_a_out at once, so a reset landing in WR cannot leave a half-finished write behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            ready_out       <= 1'b1;
            valid_out       <= 1'b0;
            err_out         <= 1'b0;
            rdata_out       <= '0;
            addr_a_byte_out <= '0;
            din_a_out       <= '0;
            we_a_out        <= 1'b0;
            en_b_out        <= 1'b0;
            addr_b_byte_out <= '0;
            we_r            <= 1'b0;
            size_r          <= '0;
            uns_r           <= 1'b0;
            addr_r          <= '0;
            wdata_r         <= '0;
            err_r           <= 1'b0;
            res_r           <= '0;
        end else begin
            valid_out <= 1'b0;
            err_out   <= 1'b0;
            rdata_out <= '0;
            we_a_out  <= 1'b0;
            en_b_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_in) begin
                        we_r      <= we_in;
                        size_r    <= size_in;
                        uns_r     <= unsigned_in;
                        addr_r    <= addr_in[AW-1:0];
                        wdata_r   <= wdata_in;
                        err_r     <= req_err;
                        res_r     <= '0;
                        ready_out <= 1'b0;
                        if (req_err) begin
                            state <= DONE;
                        end else if (we_in && size_in == SZ_WORD) begin
                            state           <= WR;
                            we_a_out        <= 1'b1;
                            addr_a_byte_out <= addr_in[AW-1:0];
                            din_a_out       <= wdata_in;
                        end else begin
                            state           <= RD;
                            en_b_out        <= 1'b1;
                            addr_b_byte_out <= addr_in[AW-1:0];
                        end
                    end
                end
                RD: state <= RD_WAIT;
                RD_WAIT: begin
                    if (we_r) begin
                        state           <= WR;
                        we_a_out        <= 1'b1;
                        addr_a_byte_out <= addr_r;
                        din_a_out       <= store_merge(dout_b_in, wdata_r, size_r, addr_r[1:0]);
                    end else begin
                        state <= DONE;
                        res_r <= load_extract(dout_b_in, size_r, addr_r[1:0], uns_r);
                    end
                end
                WR: state <= DONE;
                DONE: begin
                    state     <= IDLE;
                    ready_out <= 1'b1;
                    valid_out <= 1'b1;
                    err_out   <= err_r;
                    rdata_out <= res_r;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_lsu.sv
// Self-checking bench for sram_lsu with a behavioural sram_4k model attached.
module tb_sram_lsu;

    localparam int AW = 12;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_in = 1'b0;
    logic        we_in = 1'b0;
    logic [31:0] addr_in = '0;
    logic [1:0]  size_in = '0;
    logic        unsigned_in = 1'b0;
    logic [31:0] wdata_in = '0;
    logic        ready_out, valid_out, err_out;
    logic [31:0] rdata_out;
    logic [AW-1:0] addr_a_byte_out, addr_b_byte_out;
    logic [31:0] din_a_out;
    logic        we_a_out, en_b_out;
    logic [31:0] dout_b_in = '0;

    logic [31:0] mem [1024];

    int n_checks = 0;
    int n_fail   = 0;

    sram_lsu #(.RAM_WIDTH(32), .RAM_DEPTH(4096)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .we_in(we_in), .addr_in(addr_in),
        .size_in(size_in), .unsigned_in(unsigned_in), .wdata_in(wdata_in),
        .ready_out(ready_out), .valid_out(valid_out), .err_out(err_out),
        .rdata_out(rdata_out), .addr_a_byte_out(addr_a_byte_out), .din_a_out(din_a_out),
        .we_a_out(we_a_out), .en_b_out(en_b_out), .addr_b_byte_out(addr_b_byte_out),
        .dout_b_in(dout_b_in)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we_a_out) mem[addr_a_byte_out[AW-1:2]] <= din_a_out;
        if (en_b_out) dout_b_in <= mem[addr_b_byte_out[AW-1:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic do_req(
        input  logic        we,
        input  logic [31:0] addr,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [31:0] wdata,
        output int          lat,
        output logic        err,
        output logic [31:0] rdata,
        output int          n_en,
        output int          n_we,
        output logic [31:0] din,
        output int          first_en,
        output int          first_we
    );
        int waitc;
        lat = 0; err = 1'b0; rdata = '0; n_en = 0; n_we = 0; din = '0;
        first_en = -1; first_we = -1; waitc = 0;
        @(negedge clk);
        while (!ready_out && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        if (waitc >= 20) check("ready_timeout", 32'd0, 32'd1);
        req_in = 1'b1; we_in = we; addr_in = addr; size_in = size;
        unsigned_in = uns; wdata_in = wdata;
        @(posedge clk);
        #1 req_in = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            if (en_b_out) begin
                n_en++;
                if (first_en < 0) first_en = n;
            end
            if (we_a_out) begin
                n_we++;
                din = din_a_out;
                if (first_we < 0) first_we = n;
            end
            if (valid_out) begin
                lat = n; err = err_out; rdata = rdata_out;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic        err;
        logic [31:0] rdata;
        int          lat;
        logic [31:0] din;
    } vec_t;

    vec_t vecs [19];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat, n_en, n_we, first_en, first_we, n_valid, n_wr;
        logic err;
        logic [31:0] rdata, din;
        logic exp_en, exp_we;

        //        we    addr        size   uns   wdata          err   rdata          lat din
        vecs[0]  = '{1'b1, 32'h010, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0, 32'h00000000, 2, 32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 3, 32'h0};
        vecs[2]  = '{1'b1, 32'h012, 2'b00, 1'b0, 32'h000000A5, 1'b0, 32'h00000000, 4, 32'hDEA5BEEF};
        vecs[3]  = '{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'hDEA5BEEF, 3, 32'h0};
        vecs[4]  = '{1'b1, 32'h010, 2'b10, 1'b0, 32'h80017FFF, 1'b0, 32'h00000000, 2, 32'h80017FFF};
        vecs[5]  = '{1'b0, 32'h012, 2'b01, 1'b0, 32'h0,        1'b0, 32'hFFFF8001, 3, 32'h0};
        vecs[6]  = '{1'b0, 32'h012, 2'b01, 1'b1, 32'h0,        1'b0, 32'h00008001, 3, 32'h0};
        vecs[7]  = '{1'b0, 32'h011, 2'b00, 1'b0, 32'h0,        1'b0, 32'h0000007F, 3, 32'h0};
        vecs[8]  = '{1'b0, 32'h010, 2'b00, 1'b0, 32'h0,        1'b0, 32'hFFFFFFFF, 3, 32'h0};
        vecs[9]  = '{1'b0, 32'h013, 2'b00, 1'b1, 32'h0,        1'b0, 32'h00000080, 3, 32'h0};
        vecs[10] = '{1'b1, 32'h012, 2'b01, 1'b0, 32'hFFFF1234, 1'b0, 32'h00000000, 4, 32'h12347FFF};
        vecs[11] = '{1'b1, 32'h013, 2'b00, 1'b0, 32'h0000005A, 1'b0, 32'h00000000, 4, 32'h5A347FFF};
        vecs[12] = '{1'b0, 32'h010, 2'b10, 1'b0, 32'h0,        1'b0, 32'h5A347FFF, 3, 32'h0};
        vecs[13] = '{1'b0, 32'h010, 2'b01, 1'b0, 32'h0,        1'b0, 32'h00007FFF, 3, 32'h0};
        vecs[14] = '{1'b0, 32'h013, 2'b01, 1'b0, 32'h0,        1'b1, 32'h00000000, 1, 32'h0};
        vecs[15] = '{1'b1, 32'h002, 2'b10, 1'b0, 32'h12345678, 1'b1, 32'h00000000, 1, 32'h0};
        vecs[16] = '{1'b0, 32'h000, 2'b11, 1'b0, 32'h0,        1'b1, 32'h00000000, 1, 32'h0};
        vecs[17] = '{1'b0, 32'h1000, 2'b10, 1'b0, 32'h0,       1'b1, 32'h00000000, 1, 32'h0};
        vecs[18] = '{1'b1, 32'hFFFFFFFC, 2'b00, 1'b0, 32'h11, 1'b1, 32'h00000000, 1, 32'h0};

        for (int i = 0; i < 1024; i++) mem[i] = '0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'b0, ready_out}, 32'd1);
        check("reset_valid", {31'b0, valid_out}, 32'd0);
        check("reset_err",   {31'b0, err_out},   32'd0);
        check("reset_rdata", rdata_out,          32'd0);
        check("reset_en_b",  {31'b0, en_b_out},  32'd0);
        check("reset_we_a",  {31'b0, we_a_out},  32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            do_req(vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                   lat, err, rdata, n_en, n_we, din, first_en, first_we);
            exp_en = !vecs[i].err && !(vecs[i].we && vecs[i].size == 2'b10);
            exp_we = vecs[i].we && !vecs[i].err;
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_err", i), {31'b0, err}, {31'b0, vecs[i].err});
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].rdata);
            check($sformatf("v%0d_en_b_pulses", i), 32'(n_en), {31'b0, exp_en});
            check($sformatf("v%0d_we_a_pulses", i), 32'(n_we), {31'b0, exp_we});
            if (exp_we) check($sformatf("v%0d_din_a", i), din, vecs[i].din);
            if (exp_we && exp_en)
                check($sformatf("v%0d_read_before_write", i), {31'b0, first_en < first_we}, 32'd1);
        end

        // Reset while a byte store sits in RD_WAIT: no write, no response.
        @(negedge clk);
        check("rst_seq_ready", {31'b0, ready_out}, 32'd1);
        req_in = 1'b1; we_in = 1'b1; addr_in = 32'h010; size_in = 2'b00; wdata_in = 32'h77;
        @(posedge clk);
        #1 req_in = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_we_a",  {31'b0, we_a_out},  32'd0);
        check("rst_mid_ready", {31'b0, ready_out}, 32'd1);
        n_valid = 0; n_wr = 0;
        for (int n = 0; n < 6; n++) begin
            if (n == 2) begin
                @(negedge clk);
                rst = 1'b0;
            end
            @(posedge clk);
            #1;
            if (valid_out) n_valid++;
            if (we_a_out) n_wr++;
        end
        check("rst_mid_no_valid", 32'(n_valid), 32'd0);
        check("rst_mid_no_write", 32'(n_wr), 32'd0);
        do_req(1'b0, 32'h010, 2'b10, 1'b0, 32'h0, lat, err, rdata, n_en, n_we, din, first_en, first_we);
        check("rst_post_load", rdata, 32'h5A347FFF);
        check("rst_post_latency", 32'(lat), 32'd3);

        // A second request strobed while busy must be dropped.
        @(negedge clk);
        check("busy_seq_ready", {31'b0, ready_out}, 32'd1);
        req_in = 1'b1; we_in = 1'b1; addr_in = 32'h020; size_in = 2'b10; wdata_in = 32'h11111111;
        @(posedge clk);
        #1;
        addr_in = 32'h024; wdata_in = 32'h22222222;
        n_valid = 0; n_wr = 0;
        if (we_a_out) n_wr++;
        for (int n = 1; n < 12; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) req_in = 1'b0;
            if (valid_out) n_valid++;
            if (we_a_out) n_wr++;
        end
        check("busy_one_valid", 32'(n_valid), 32'd1);
        check("busy_one_write", 32'(n_wr), 32'd1);
        do_req(1'b0, 32'h020, 2'b10, 1'b0, 32'h0, lat, err, rdata, n_en, n_we, din, first_en, first_we);
        check("busy_accepted_word", rdata, 32'h11111111);
        do_req(1'b0, 32'h024, 2'b10, 1'b0, 32'h0, lat, err, rdata, n_en, n_we, din, first_en, first_we);
        check("busy_ignored_word", rdata, 32'h00000000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
